adder16_operand_feeder: RTL
===========================

ADDER16_OPERAND_FEEDER -- requirements
Module: adder16_operand_feeder

Interface
REQ-001 Parameter DEPTH, default 4, operand FIFO entries (power of two, >=2).
REQ-002 Parameter PIPE_LAT, default 4, edges from add_a/add_b/add_cin change to matching add_sum/add_cout valid.
REQ-003 clk  input  1  single rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous, active-low reset; all state cleared while low.
REQ-005 in_a, in_b  input  16 each  operand pair offered by producer.
REQ-006 in_cin  input  1  carry-in offered with operand pair.
REQ-007 in_valid  input  1  producer offers in_a/in_b/in_cin this cycle.
REQ-008 in_ready  output  1  feeder accepts offer this cycle.
REQ-009 pipe_hold  input  1  high blocks issue to the adder (bubble inserted).
REQ-010 add_a, add_b  output  16 each  registered operands driven into the pipelined 16-bit adder.
REQ-011 add_cin  output  1  registered carry-in driven into the adder.
REQ-012 add_sum  input  16, add_cout  input  1  adder results.
REQ-013 res_sum  output  16, res_cout  output  1  captured result for the consumer.
REQ-014 res_valid  output  1  one-cycle pulse per captured result; no backpressure.
REQ-015 fifo_count  output  $clog2(DEPTH)+1  entries currently held.

Function
REQ-016 Push when in_valid && in_ready; in_ready = (fifo_count < DEPTH), driven from registered count only.
REQ-017 When full, in_ready=0 even if a pop occurs the same edge; no push, no data loss.
REQ-018 Issue at an edge when FIFO non-empty and pipe_hold=0: head popped into add_a/add_b/add_cin, issue flag=1.
REQ-019 No issue at an edge (empty or pipe_hold=1): add_a=0, add_b=0, add_cin=0, issue flag=0.
REQ-020 No bypass: an entry pushed at edge e is issued no earlier than edge e+1; first result from empty feeder appears after edge e+PIPE_LAT+2.
REQ-021 Simultaneous push and pop: fifo_count unchanged; FIFO order preserved.
REQ-022 Valid tracker: shift register of PIPE_LAT+1 stages; stage 0 loads issue flag at each edge, shifts every edge regardless of pipe_hold.
REQ-023 At an edge where tracker tail=1: res_sum<=add_sum, res_cout<=add_cout, res_valid<=1; otherwise res_valid<=0, res_sum/res_cout hold.
REQ-024 Throughput one result per cycle; results leave in issue order, one per issued entry, none duplicated or dropped.
REQ-025 FIFO read/write pointers wrap modulo DEPTH.

Reset
REQ-026 reset low: fifo_count=0, pointers=0, tracker=0, add_a=add_b=0, add_cin=0, res_sum=0, res_cout=0, res_valid=0, in_ready=1 (combinational from count).
REQ-027 reset asserted mid-operation discards queued and in-flight items; no res_valid for them after release.
REQ-028 First push accepted at first rising edge with reset high.

Configuration
REQ-029 Macro FEEDER_ISSUE_CNT_EN defined: output issue_count (16 bits), reset 0, +1 per issue, wraps 0xFFFF->0x0000.
REQ-030 Macro undefined: issue_count port and counter absent; all other behaviour identical.

Verification (DEPTH=4, PIPE_LAT=4, behavioural adder model of latency 4)
REQ-031 Reset held low 3 cycles with in_valid=1 -> all outputs 0, in_ready=1, fifo_count=0, no res_valid.
REQ-032 Single push a=1,b=2,cin=0 at edge 0 -> add_a=1,add_b=2 after edge 1; res_valid=1, res_sum=3, res_cout=0 after edge 6 only.
REQ-033 Pushes 1+2,2+3,3+4,4+5,5+6 on consecutive edges -> res_sum 3,5,7,9,11 on 5 consecutive cycles.
REQ-034 pipe_hold=1, push 5 pairs -> 4 accepted, in_ready=0, fifo_count=4; release hold -> 4 results in order, 5th accepted on next free edge.
REQ-035 a=0xFFFF,b=0x0001,cin=0 -> res_sum=0x0000,res_cout=1; a=0xFFFF,b=0xFFFF,cin=1 -> res_sum=0xFFFF,res_cout=1.
REQ-036 reset pulsed low 2 edges after 3 pushes -> no res_valid afterward, fifo_count=0; with FEEDER_ISSUE_CNT_EN, issue_count=0 after reset.

Source files
------------

// File: rtl/adder16_operand_feeder.sv
// adder16_operand_feeder
//   Buffers operand pairs from a producer in a small FIFO, issues them one per
//   cycle into an external pipelined 16-bit adder and captures the adder's
//   result when the matching issue has travelled through a valid tracker.
//
// Parameters
//   DEPTH     operand FIFO entries (power of two, >= 2)
//   PIPE_LAT  edges from add_a/add_b/add_cin change to matching add_sum valid
//
// Ports
//   clk                     rising-edge clock
//   reset                   asynchronous active-low reset
//   in_a, in_b, in_cin      operand pair + carry offered by producer
//   in_valid / in_ready     producer handshake (ready from registered count)
//   pipe_hold               blocks issue to the adder (bubble inserted)
//   add_a, add_b, add_cin   registered operands into the adder (0 on bubble)
//   add_sum, add_cout       adder results
//   res_sum, res_cout       captured result for the consumer
//   res_valid               one-cycle pulse per captured result
//   fifo_count              entries currently held
//   issue_count             (only with FEEDER_ISSUE_CNT_EN) wrapping issue count
//
// Optional feature macro: FEEDER_ISSUE_CNT_EN
module adder16_operand_feeder #(
  parameter int DEPTH    = 4,
  parameter int PIPE_LAT = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [15:0]              in_a,
  input  logic [15:0]              in_b,
  input  logic                     in_cin,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     pipe_hold,
  output logic [15:0]              add_a,
  output logic [15:0]              add_b,
  output logic                     add_cin,
  input  logic [15:0]              add_sum,
  input  logic                     add_cout,
  output logic [15:0]              res_sum,
  output logic                     res_cout,
  output logic                     res_valid,
  output logic [$clog2(DEPTH):0]   fifo_count
`ifdef FEEDER_ISSUE_CNT_EN
  ,
  output logic [15:0]              issue_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_nxt;
  logic [32:0]     mem [DEPTH];
  logic [PIPE_LAT:0] trk;
  logic            push;
  logic            issue;

  // Ready depends on the registered count only, so a full FIFO refuses a push
  // even on an edge where it also pops.
  assign in_ready   = (cnt < CW'(DEPTH));
  assign push       = in_valid & in_ready;
  assign issue      = (cnt != '0) & ~pipe_hold;
  assign fifo_count = cnt;

  always_comb begin
    cnt_nxt = cnt;
    unique case ({push, issue})
      2'b10:   cnt_nxt = cnt + CW'(1);
      2'b01:   cnt_nxt = cnt - CW'(1);
      default: cnt_nxt = cnt;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      wptr <= '0;
      rptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      cnt <= cnt_nxt;
      if (push) begin
        mem[wptr] <= {in_cin, in_a, in_b};
        wptr      <= wptr + AW'(1);
      end
      if (issue) rptr <= rptr + AW'(1);
    end
  end

  // Operand registers present zeros on a bubble so the adder sees a clean idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      add_a   <= '0;
      add_b   <= '0;
      add_cin <= 1'b0;
    end else if (issue) begin
      {add_cin, add_a, add_b} <= mem[rptr];
    end else begin
      add_a   <= '0;
      add_b   <= '0;
      add_cin <= 1'b0;
    end
  end

  // Tracker stage k holds the issue flag from k edges ago; the tail lines up
  // with the edge after the adder output becomes valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      trk <= '0;
    end else begin
      trk <= {trk[PIPE_LAT-1:0], issue};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      res_sum   <= '0;
      res_cout  <= 1'b0;
      res_valid <= 1'b0;
    end else if (trk[PIPE_LAT]) begin
      res_sum   <= add_sum;
      res_cout  <= add_cout;
      res_valid <= 1'b1;
    end else begin
      res_valid <= 1'b0;
    end
  end

`ifdef FEEDER_ISSUE_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     issue_count <= '0;
    else if (issue) issue_count <= issue_count + 16'd1;
  end
`endif

endmodule
